ecc_scalar_mult_sequencer: RTL and testbench

//  Parametrised ECC scalar-multiplication controller: k*P by MSB-first double-and-add.

---
 rtl/ecc_sm_pkg.sv | 34 +++
 rtl/ecc_scalar_mult_sequencer_if.sv | 32 +++
 rtl/ecc_sm_key_shifter.sv | 54 +++++
 rtl/ecc_scalar_mult_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ecc_scalar_mult_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_sm_pkg.sv
// Shared types for the ECC scalar-multiplication sequencer: FSM states,
// point-engine command encodings, transfer directions and counter sizing.
package ecc_sm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_Y,
    ST_LOAD_A,
    ST_SCAN,
    ST_INIT_X,
    ST_INIT_Y,
    ST_NEXT,
    ST_DBL,
    ST_ADD,
    ST_STORE_X,
    ST_STORE_Y
  } sm_state_e;

  typedef enum logic [1:0] {
    PT_IDLE  = 2'b00,
    PT_ADD   = 2'b01,
    PT_DBL   = 2'b10,
    PT_DUMMY = 2'b11
  } pt_cmd_e;

  localparam logic XFER_IN  = 1'b0;
  localparam logic XFER_OUT = 1'b1;

  function automatic int cnt_width(input int key_w);
    return (key_w > 1) ? $clog2(key_w) : 1;
  endfunction

endpackage

// File: rtl/ecc_scalar_mult_sequencer_if.sv
// Handshake bundle between the sequencer and its command decoder / engines.
// master = sequencer side, slave = the surrounding decoder and engines.
interface ecc_scalar_mult_sequencer_if #(
  parameter int KEY_W  = 576,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic              done;
  logic              err_zero_key;
  logic              xfer_cmd;
  logic              xfer_dir;
  logic [ADDR_W-1:0] xfer_rd_addr;
  logic [ADDR_W-1:0] xfer_wr_addr;
  logic              xfer_done;
  logic [1:0]        pt_cmd;
  logic              add_done;
  logic              dbl_done;

  modport master (
    input  start, key, xfer_done, add_done, dbl_done,
    output busy, done, err_zero_key, xfer_cmd, xfer_dir,
           xfer_rd_addr, xfer_wr_addr, pt_cmd
  );

  modport slave (
    output start, key, xfer_done, add_done, dbl_done,
    input  busy, done, err_zero_key, xfer_cmd, xfer_dir,
           xfer_rd_addr, xfer_wr_addr, pt_cmd
  );
endinterface

// File: rtl/ecc_sm_key_shifter.sv
// Scalar register for the sequencer: loads k, shifts left one bit at a time,
// tracks the current bit index and remembers whether k was zero.
module ecc_sm_key_shifter
  import ecc_sm_pkg::*;
#(
  parameter int KEY_W = 576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [KEY_W-1:0] key_in,
  output logic             msb,
  output logic             cnt_zero,
  output logic             key_zero
);
  localparam int CNT_W = cnt_width(KEY_W);

  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_shl;
  logic [CNT_W-1:0] cnt_reg;
  logic             zero_reg;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_shl
      if (gi == 0) begin : g_lsb
        assign key_shl[gi] = 1'b0;
      end else begin : g_bit
        assign key_shl[gi] = key_reg[gi-1];
      end
    end
  endgenerate

  // cnt_reg is the index of the bit currently sitting in the MSB position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg  <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
    end else if (load) begin
      key_reg  <= key_in;
      cnt_reg  <= CNT_W'(KEY_W - 1);
      zero_reg <= (key_in == '0);
    end else if (shift) begin
      key_reg  <= key_shl;
      cnt_reg  <= cnt_reg - CNT_W'(1);
    end
  end

  assign msb      = key_reg[KEY_W-1];
  assign cnt_zero = (cnt_reg == '0);
  assign key_zero = zero_reg;
endmodule

// File: rtl/ecc_scalar_mult_sequencer.sv
// MSB-first double-and-add controller for k*P, issuing RAM transfers and point ops.
// Define ECC_SM_CONST_TIME_EN for the constant-time variant (no leading-zero scan).
module ecc_scalar_mult_sequencer
  import ecc_sm_pkg::*;
#(
  parameter int              KEY_W    = 576,
  parameter int              ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] P_X_ADDR = 6'h03,
  parameter logic [ADDR_W-1:0] P_Y_ADDR = 6'h06,
  parameter logic [ADDR_W-1:0] A_ADDR   = 6'h09,
  parameter logic [ADDR_W-1:0] Q_X_ADDR = 6'h21,
  parameter logic [ADDR_W-1:0] Q_Y_ADDR = 6'h27
) (
  input logic clk,
  input logic rst,
  ecc_scalar_mult_sequencer_if.master bus
);
`ifdef ECC_SM_CONST_TIME_EN
  localparam sm_state_e AFTER_LOAD = ST_INIT_X;
  localparam sm_state_e AFTER_INIT = ST_DBL;
  logic q_valid_reg, q_valid_next;
`else
  localparam sm_state_e AFTER_LOAD = ST_SCAN;
  localparam sm_state_e AFTER_INIT = ST_NEXT;
`endif

  sm_state_e         state_reg, state_next, x_after;
  logic              busy_reg, busy_next, done_reg, done_next, err_reg, err_next;
  logic              xfer_cmd_reg, xfer_cmd_next, xfer_dir_reg, xfer_dir_next;
  logic [ADDR_W-1:0] rd_reg, rd_next, wr_reg, wr_next, x_src, x_dst;
  logic [1:0]        pt_cmd_reg, pt_cmd_next;
  logic              issued_reg, issued_next;
  logic              is_xfer, x_dir;
  logic              sh_load, sh_shift, sh_msb, sh_cnt_zero, sh_key_zero;

  ecc_sm_key_shifter #(.KEY_W(KEY_W)) u_key (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .key_in   (bus.key),
    .msb      (sh_msb),
    .cnt_zero (sh_cnt_zero),
    .key_zero (sh_key_zero)
  );

  // Transfer parameters for every state that moves a RAM slot
  always_comb begin
    is_xfer = 1'b1;
    x_dir   = XFER_IN;
    x_src   = P_X_ADDR;
    x_dst   = P_X_ADDR;
    x_after = ST_IDLE;
    case (state_reg)
      ST_LOAD_X:  x_after = ST_LOAD_Y;
      ST_LOAD_Y:  begin x_src = P_Y_ADDR; x_dst = P_Y_ADDR; x_after = ST_LOAD_A; end
      ST_LOAD_A:  begin x_src = A_ADDR;   x_dst = A_ADDR;   x_after = AFTER_LOAD; end
      ST_INIT_X:  begin x_dst = Q_X_ADDR; x_after = ST_INIT_Y; end
      ST_INIT_Y:  begin x_src = P_Y_ADDR; x_dst = Q_Y_ADDR; x_after = AFTER_INIT; end
      ST_STORE_X: begin x_dir = XFER_OUT; x_src = Q_X_ADDR; x_dst = Q_X_ADDR; x_after = ST_STORE_Y; end
      ST_STORE_Y: begin x_dir = XFER_OUT; x_src = Q_Y_ADDR; x_dst = Q_Y_ADDR; x_after = ST_IDLE; end
      default:    is_xfer = 1'b0;
    endcase
  end

  // issued_reg marks that this state's command went out; only then is its done awaited
  always_comb begin
    state_next    = state_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    xfer_cmd_next = 1'b0;
    xfer_dir_next = xfer_dir_reg;
    rd_next       = rd_reg;
    wr_next       = wr_reg;
    pt_cmd_next   = PT_IDLE;
    issued_next   = issued_reg;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
`ifdef ECC_SM_CONST_TIME_EN
    q_valid_next  = q_valid_reg;
`endif
    if (is_xfer) begin
      if (!issued_reg) begin
        xfer_cmd_next = 1'b1;
        xfer_dir_next = x_dir;
        rd_next       = x_src;
        wr_next       = x_dst;
        issued_next   = 1'b1;
      end else if (bus.xfer_done) begin
        issued_next = 1'b0;
        state_next  = x_after;
        if (state_reg == ST_STORE_Y) begin
          done_next = 1'b1;
          err_next  = sh_key_zero;
          busy_next = 1'b0;
        end
      end
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.start) begin
          sh_load    = 1'b1;
          busy_next  = 1'b1;
          state_next = ST_LOAD_X;
`ifdef ECC_SM_CONST_TIME_EN
          q_valid_next = 1'b0;
`endif
        end
        ST_SCAN: begin
          if (sh_msb) begin
            state_next = ST_INIT_X;
          end else if (sh_cnt_zero) begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            sh_shift = 1'b1;
          end
        end
        ST_NEXT: begin
          if (sh_cnt_zero) begin
            state_next = ST_STORE_X;
          end else begin
            sh_shift   = 1'b1;
            state_next = ST_DBL;
          end
        end
        ST_DBL: begin
          if (!issued_reg) begin
            pt_cmd_next = PT_DBL;
            issued_next = 1'b1;
          end else if (bus.dbl_done) begin
            issued_next = 1'b0;
`ifdef ECC_SM_CONST_TIME_EN
            state_next  = ST_ADD;
`else
            state_next  = sh_msb ? ST_ADD : ST_NEXT;
`endif
          end
        end
        ST_ADD: begin
          if (!issued_reg) begin
`ifdef ECC_SM_CONST_TIME_EN
            pt_cmd_next  = (sh_msb && q_valid_reg) ? PT_ADD : PT_DUMMY;
            q_valid_next = q_valid_reg | sh_msb;
`else
            pt_cmd_next  = PT_ADD;
`endif
            issued_next = 1'b1;
          end else if (bus.add_done) begin
            issued_next = 1'b0;
            state_next  = ST_NEXT;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      xfer_cmd_reg <= 1'b0;
      xfer_dir_reg <= 1'b0;
      rd_reg       <= '0;
      wr_reg       <= '0;
      pt_cmd_reg   <= PT_IDLE;
      issued_reg   <= 1'b0;
`ifdef ECC_SM_CONST_TIME_EN
      q_valid_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      xfer_cmd_reg <= xfer_cmd_next;
      xfer_dir_reg <= xfer_dir_next;
      rd_reg       <= rd_next;
      wr_reg       <= wr_next;
      pt_cmd_reg   <= pt_cmd_next;
      issued_reg   <= issued_next;
`ifdef ECC_SM_CONST_TIME_EN
      q_valid_reg  <= q_valid_next;
`endif
    end
  end

  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.err_zero_key = err_reg;
  assign bus.xfer_cmd     = xfer_cmd_reg;
  assign bus.xfer_dir     = xfer_dir_reg;
  assign bus.xfer_rd_addr = rd_reg;
  assign bus.xfer_wr_addr = wr_reg;
  assign bus.pt_cmd       = pt_cmd_reg;
endmodule

// File: tb/tb_ecc_scalar_mult_sequencer.sv
// Directed + random bench for ecc_scalar_mult_sequencer with fixed-latency engine
// models and a bit-level double-and-add reference (ECC_SM_CONST_TIME_EN aware).
module tb_ecc_scalar_mult_sequencer;
  localparam int KW       = 16;
  localparam int XFER_LAT = 3;
  localparam int PT_LAT   = 4;
  localparam int LIMIT    = 3000;

  logic clk = 1'b0;
  logic rst;
  logic inject_stray = 1'b0;
  logic [1:0] eng_cmd;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_lone = 0;
  int last_cycles = 0;
  logic [12:0] xq[$];
  logic [1:0]  pq[$];

  ecc_scalar_mult_sequencer_if #(.KEY_W(KW), .ADDR_W(6)) bus ();

  ecc_scalar_mult_sequencer #(.KEY_W(KW), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Transfer engine: done pulse XFER_LAT cycles after each request
  initial begin
    bus.xfer_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.xfer_done = 1'b0;
      if (bus.xfer_cmd) begin
        repeat (XFER_LAT - 1) @(posedge clk);
        #1 bus.xfer_done = 1'b1;
      end
    end
  end

  // Point engine: optional stray add_done while a double is pending
  initial begin
    bus.add_done = 1'b0;
    bus.dbl_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.add_done = 1'b0;
      bus.dbl_done = 1'b0;
      if (bus.pt_cmd != 2'b00) begin
        eng_cmd = bus.pt_cmd;
        if (eng_cmd == 2'b10 && inject_stray) begin
          @(posedge clk); #1 bus.add_done = 1'b1;
          @(posedge clk); #1 bus.add_done = 1'b0;
        end
        repeat (PT_LAT - 1) @(posedge clk);
        #1;
        if (eng_cmd == 2'b10) bus.dbl_done = 1'b1;
        else                  bus.add_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.xfer_cmd) xq.push_back({bus.xfer_dir, bus.xfer_rd_addr, bus.xfer_wr_addr});
      if (bus.pt_cmd != 2'b00) pq.push_back(bus.pt_cmd);
      if (bus.done) done_cnt++;
      if (bus.err_zero_key) begin
        err_cnt++;
        if (!bus.done) err_lone++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  function automatic logic [12:0] xf(input logic dir, input logic [5:0] rd, input logic [5:0] wr);
    return {dir, rd, wr};
  endfunction

  function automatic logic [18:0] all_outs();
    return {bus.busy, bus.done, bus.err_zero_key, bus.xfer_cmd, bus.xfer_dir,
            bus.xfer_rd_addr, bus.xfer_wr_addr, bus.pt_cmd};
  endfunction

  task automatic run_key(input logic [KW-1:0] k, input bit glitch);
    int xb, pb, db, eb, cyc, m, dbls, adds;
    bit seen;
    logic [12:0] exp_x[$];
    logic [1:0]  exp_p[$];
    xb = xq.size(); pb = pq.size(); db = done_cnt; eb = err_cnt;
    inject_stray = glitch;
    step();
    bus.start = 1'b1; bus.key = k;
    step();
    bus.start = 1'b0; bus.key = KW'($urandom);
    check("busy_after_start", bus.busy, 1);
    cyc = 1;
    if (glitch) begin
      repeat (6) begin step(); cyc++; end
      bus.start = 1'b1; bus.key = ~k;
      step(); cyc++;
      bus.start = 1'b0;
    end
    while (done_cnt == db && cyc < LIMIT) begin step(); cyc++; end
    last_cycles = cyc;
    check("done_timeout", (cyc < LIMIT), 1);
    check("busy_at_done", bus.busy, 0);
    repeat (5) step();
    inject_stray = 1'b0;
    check("done_pulses", done_cnt - db, 1);
    check("err_zero_key", err_cnt - eb, (k == '0) ? 1 : 0);
    check("err_without_done", err_lone, 0);

    // Reference: loads, then (k!=0 or constant-time) P->Q copies, ops, Q stores
    exp_x.push_back(xf(1'b0, 6'h03, 6'h03));
    exp_x.push_back(xf(1'b0, 6'h06, 6'h06));
    exp_x.push_back(xf(1'b0, 6'h09, 6'h09));
`ifdef ECC_SM_CONST_TIME_EN
    seen = 1'b0;
    for (int i = KW - 1; i >= 0; i--) begin
      exp_p.push_back(2'b10);
      exp_p.push_back((k[i] && seen) ? 2'b01 : 2'b11);
      seen = seen | k[i];
    end
    if (1'b1) begin
`else
    m = 0;
    for (int i = 0; i < KW; i++) if (k[i]) m = i;
    for (int i = m - 1; i >= 0; i--) begin
      exp_p.push_back(2'b10);
      if (k[i]) exp_p.push_back(2'b01);
    end
    if (k != '0) begin
`endif
      exp_x.push_back(xf(1'b0, 6'h03, 6'h21));
      exp_x.push_back(xf(1'b0, 6'h06, 6'h27));
      exp_x.push_back(xf(1'b1, 6'h21, 6'h21));
      exp_x.push_back(xf(1'b1, 6'h27, 6'h27));
    end

    check("xfer_count", xq.size() - xb, exp_x.size());
    for (int i = 0; i < exp_x.size() && xb + i < xq.size(); i++)
      check($sformatf("xfer[%0d]", i), xq[xb + i], exp_x[i]);
    check("pt_count", pq.size() - pb, exp_p.size());
    for (int i = 0; i < exp_p.size() && pb + i < pq.size(); i++)
      check($sformatf("pt[%0d]", i), pq[pb + i], exp_p[i]);
`ifndef ECC_SM_CONST_TIME_EN
    dbls = 0; adds = 0;
    for (int i = pb; i < pq.size(); i++) begin
      if (pq[i] == 2'b10) dbls++;
      if (pq[i] == 2'b01) adds++;
    end
    if (k != '0) begin
      check("double_count", dbls, m);
      check("add_count", adds, $countones(k) - 1);
    end
`endif
    $display("txn k=%h glitch=%0d cycles=%0d pt_ops=%0d xfers=%0d", k, glitch, cyc,
             pq.size() - pb, xq.size() - xb);
  endtask

  initial begin
    int pb, db, dbl_seen, cyc, c1;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    repeat (3) step();
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    step();
    check("idle_outputs", all_outs(), 0);

    run_key(KW'(1), 1'b0);
    run_key(KW'(16'h000B), 1'b0);
    run_key('0, 1'b0);

    // Reset during the second double of k=0xFF
    pb = pq.size(); db = done_cnt;
    step();
    bus.start = 1'b1; bus.key = KW'(16'h00FF);
    step();
    bus.start = 1'b0;
    dbl_seen = 0; cyc = 0;
    while (dbl_seen < 2 && cyc < LIMIT) begin
      step(); cyc++;
      dbl_seen = 0;
      for (int i = pb; i < pq.size(); i++) if (pq[i] == 2'b10) dbl_seen++;
    end
    check("second_double_seen", dbl_seen, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("outputs_after_abort", all_outs(), 0);
    step(); step();
    rst = 1'b0;
    repeat (30) step();
    check("no_done_after_abort", done_cnt - db, 0);
    check("idle_after_abort", all_outs(), 0);
    $display("txn k=00ff aborted by reset after %0d doubles", dbl_seen);

    run_key(KW'(16'h000B), 1'b0);
    run_key(KW'(16'hA5C3), 1'b1);
    run_key(KW'(1) << (KW - 1), 1'b0);
    run_key('1, 1'b0);
    for (int n = 0; n < 6; n++) run_key(KW'($urandom), (n % 2) == 1);

`ifdef ECC_SM_CONST_TIME_EN
    run_key(KW'(1), 1'b0);
    c1 = last_cycles;
    run_key(KW'(1) << (KW - 1), 1'b0);
    check("const_time_cycles", last_cycles, c1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
